// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: frame-sequencer state encoding, frame-format
// constants and the baud divisor helper. Intended to be shared by the
// transmitter and by a future receiver rework.
// Ports: none (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame sequencer states, in line order.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_PARITY_EVEN  = 1;
    localparam int UART_DEFAULT_BAUD = 9600;

    // Clock cycles per bit period (integer division, truncating).
    function automatic int baud_div(input int frequency, input int baud);
        return frequency / baud;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running bit-period counter. Counts 0..DIV-1 and asserts `tick` for the
// single cycle in which the count equals DIV-1; the count wraps to 0 on that
// same edge. `clear` restarts the period so a new frame gets a full first bit.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clear - restart the bit period (count returns to 0 on the next edge)
//   tick  - last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = (clear || tick) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: accepts a byte on a valid/ready handshake and sends
// start bit, 8 data bits LSB first, even parity and STOP_BITS stop bits
// (STOP_BITS legal range 1..2). Every bit lasts frequency/BAUD clock cycles.
// Ports:
//   clk_tx        - clock
//   rst           - synchronous active-high reset; abandons any frame in flight
//   data_in       - byte to send, sampled only on accept
//   data_valid_in - upstream offers data_in
//   ready         - byte can be accepted this cycle (IDLE and not in reset)
//   tx_out        - registered serial line, idle high
//   busy          - frame in progress
//   done          - one-cycle pulse after the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int frequency = 50_000_000,
    parameter int BAUD      = UART_DEFAULT_BAUD,
    parameter int STOP_BITS = 2
) (
    input  logic       clk_tx,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid_in,
    output logic       ready,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int         DIV           = baud_div(frequency, BAUD);
    localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);
    localparam logic       PARITY_INV    = (UART_PARITY_EVEN == 0);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

    logic        tick;
    logic        accept;

    assign ready  = (state_q == ST_IDLE) && !rst;
    assign accept = data_valid_in && ready;
    assign busy   = (state_q != ST_IDLE);
    assign tx_out = tx_q;
    assign done   = done_q;

    // Restarting the divisor on accept gives the start bit a full period.
    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk   (clk_tx),
        .rst   (rst),
        .clear (accept),
        .tick  (tick)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        tx_d      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = data_in;
                    parity_d  = (^data_in) ^ PARITY_INV;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The line level is derived from the state being entered so that the
        // registered tx_out changes on the same edge as the state.
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule : uart_tx
